// File: rtl/hs_fifo_sfifo_pkt_pkg.sv
// Shared types and helpers for the packet-aware single-clock FIFO.
// bool_e is the project-wide flag type; it is carried here so this slice builds standalone.
package hs_fifo_sfifo_pkt_pkg;

  typedef enum logic {
    FALSE = 1'b0,
    TRUE  = 1'b1
  } bool_e;

  typedef enum logic {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } state_e;

  // Pointer width: one extra bit beyond the address so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hs_fifo_sfifo_pkt_oreg.sv
// Two-entry valid/ready output slice for hs_fifo_sfifo_pkt.
// in_ready depends only on the registered occupancy, so the FIFO read path is cut
// while back-to-back beats still flow at one per cycle.
module hs_fifo_sfifo_pkt_oreg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] ent [2];
  logic [1:0]   cnt;
  logic         head;
  logic         tail;
  logic         push;
  logic         pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = out_valid ? ent[head] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Tiny circular buffer: write at tail, read at head, occupancy tracks the net change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent[0] <= '0;
      ent[1] <= '0;
      cnt    <= 2'd0;
      head   <= 1'b0;
      tail   <= 1'b0;
    end else begin
      if (push) begin
        ent[tail] <= in_data;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/hs_fifo_sfifo_pkt.sv
// Single-clock valid/ready FIFO with optional packet mode (commit on last, drop, oversize discard).
// Optional output slice: define HS_FIFO_SFIFO_PKT_OUTPUT_REG_EN to register m_* through
// hs_fifo_sfifo_pkt_oreg (2-cycle first-beat latency); otherwise m_* read the array directly.
module hs_fifo_sfifo_pkt
  import hs_fifo_sfifo_pkt_pkg::*;
#(
  parameter type   DATA_TYPE        = logic [15:0],
  parameter int    FIFO_DEPTH       = 32,
  parameter int    ALMOST_FULL_LVL  = FIFO_DEPTH,
  parameter int    ALMOST_EMPTY_LVL = 0,
  parameter bool_e EN_PACKET_MODE   = FALSE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  DATA_TYPE                 s_data,
  input  logic                     s_last,
  input  logic                     s_drop,
  output logic                     m_valid,
  input  logic                     m_ready,
  output DATA_TYPE                 m_data,
  output logic                     m_last,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     pkt_dropped
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL_LVL);
  localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY_LVL);

  typedef struct packed {
    DATA_TYPE data;
    logic     last;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] cmt_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] cmt_ptr_nxt;
  state_e        state;
  state_e        state_nxt;
  logic          drop_nxt;
  logic          wr_en;
  logic          s_ready_i;
  logic [PW-1:0] fill;
  logic [PW-1:0] count_i;
  logic          full_i;
  logic          fifo_valid;
  logic          fifo_pop;
  entry_t        fifo_head;

  // Fill counts speculative beats too; count only what the reader may see.
  assign fill    = wr_ptr - rd_ptr;
  assign count_i = cmt_ptr - rd_ptr;
  assign full_i  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

  // Write-side control: acceptance, commit, drop and the oversize-discard FSM.
  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    cmt_ptr_nxt = cmt_ptr;
    drop_nxt    = 1'b0;
    wr_en       = 1'b0;
    s_ready_i   = !full_i;
    if (EN_PACKET_MODE == TRUE) begin
      if (state == ACCEPT) begin
        if (full_i && (count_i == '0) && s_valid) begin
          wr_ptr_nxt = cmt_ptr;
          drop_nxt   = 1'b1;
          state_nxt  = DISCARD;
        end else if (s_valid && s_ready_i) begin
          if (s_last && s_drop) begin
            wr_ptr_nxt = cmt_ptr;
            drop_nxt   = 1'b1;
          end else begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + PW'(1);
            if (s_last) begin
              cmt_ptr_nxt = wr_ptr + PW'(1);
            end
          end
        end
      end else begin
        s_ready_i = 1'b1;
        if (s_valid && s_last) begin
          state_nxt = ACCEPT;
        end
      end
    end else begin
      if (s_valid && s_ready_i) begin
        wr_en      = 1'b1;
        wr_ptr_nxt = wr_ptr + PW'(1);
      end
      cmt_ptr_nxt = wr_ptr_nxt;
    end
  end

  // Pointer, FSM and drop-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      cmt_ptr     <= '0;
      rd_ptr      <= '0;
      state       <= ACCEPT;
      pkt_dropped <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      cmt_ptr     <= cmt_ptr_nxt;
      rd_ptr      <= rd_ptr + PW'(fifo_pop);
      state       <= state_nxt;
      pkt_dropped <= drop_nxt;
    end
  end

  // Storage array write; contents need no reset because pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[PW-2:0]] <= '{data: s_data, last: s_last};
    end
  end

  assign fifo_valid = (count_i != '0);
  assign fifo_head  = mem[rd_ptr[PW-2:0]];

`ifdef HS_FIFO_SFIFO_PKT_OUTPUT_REG_EN
  logic   oreg_in_ready;
  entry_t oreg_out;

  assign fifo_pop = fifo_valid && oreg_in_ready;

  hs_fifo_sfifo_pkt_oreg #(
    .W($bits(entry_t))
  ) u_oreg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fifo_valid),
    .in_ready  (oreg_in_ready),
    .in_data   (fifo_head),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (oreg_out)
  );

  assign m_data = oreg_out.data;
  assign m_last = oreg_out.last;
`else
  assign fifo_pop = fifo_valid && m_ready;
  assign m_valid  = fifo_valid;
  assign m_data   = fifo_valid ? fifo_head.data : '0;
  assign m_last   = fifo_valid && fifo_head.last;
`endif

  assign s_ready      = s_ready_i;
  assign count        = count_i;
  assign full         = full_i;
  assign almost_full  = (fill >= AF_LVL);
  assign almost_empty = (count_i <= AE_LVL);

endmodule

// File: tb/tb_hs_fifo_sfifo_pkt.sv
// Bench for hs_fifo_sfifo_pkt: one stream-mode and one packet-mode instance share the
// same stimulus; each is compared every cycle against a queue-based model of its mode.
module tb_hs_fifo_sfifo_pkt;
  import hs_fifo_sfifo_pkt_pkg::*;

  localparam int D   = 32;
  localparam int AFL = 28;
  localparam int AEL = 2;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic        s_drop;
  logic        m_ready;

  logic        s_ready_o      [2];
  logic        m_valid_o      [2];
  logic [15:0] m_data_o       [2];
  logic        m_last_o       [2];
  logic [5:0]  count_o        [2];
  logic        full_o         [2];
  logic        almost_full_o  [2];
  logic        almost_empty_o [2];
  logic        pkt_dropped_o  [2];

  int total;
  int bad;

  logic [16:0] cq [2][$];
  logic [16:0] sq [2][$];
  bit          disc [2];
  bit          drop_pend [2];

  hs_fifo_sfifo_pkt #(
    .FIFO_DEPTH(D), .ALMOST_FULL_LVL(AFL), .ALMOST_EMPTY_LVL(AEL), .EN_PACKET_MODE(FALSE)
  ) u_np (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_o[0]), .s_data(s_data),
    .s_last(s_last), .s_drop(s_drop), .m_valid(m_valid_o[0]), .m_ready(m_ready),
    .m_data(m_data_o[0]), .m_last(m_last_o[0]), .count(count_o[0]), .full(full_o[0]),
    .almost_full(almost_full_o[0]), .almost_empty(almost_empty_o[0]),
    .pkt_dropped(pkt_dropped_o[0])
  );

  hs_fifo_sfifo_pkt #(
    .FIFO_DEPTH(D), .ALMOST_FULL_LVL(AFL), .ALMOST_EMPTY_LVL(AEL), .EN_PACKET_MODE(TRUE)
  ) u_pk (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_o[1]), .s_data(s_data),
    .s_last(s_last), .s_drop(s_drop), .m_valid(m_valid_o[1]), .m_ready(m_ready),
    .m_data(m_data_o[1]), .m_last(m_last_o[1]), .count(count_o[1]), .full(full_o[1]),
    .almost_full(almost_full_o[1]), .almost_empty(almost_empty_o[1]),
    .pkt_dropped(pkt_dropped_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      cq[k].delete();
      sq[k].delete();
      disc[k]      = 1'b0;
      drop_pend[k] = 1'b0;
    end
  endtask

  // Expected outputs for the current inputs, derived from queue occupancy.
  task automatic compareDut(input int k);
    int    fill;
    int    cnt;
    string nm;
    fill = cq[k].size() + sq[k].size();
    cnt  = cq[k].size();
    nm   = (k == 0) ? "np" : "pk";
    checkOutput({nm, " s_ready"}, 32'(s_ready_o[k]), 32'((k == 1 && disc[k]) || fill != D));
    checkOutput({nm, " m_valid"}, 32'(m_valid_o[k]), 32'(cnt != 0));
    checkOutput({nm, " count"}, 32'(count_o[k]), 32'(cnt));
    checkOutput({nm, " full"}, 32'(full_o[k]), 32'(fill == D));
    checkOutput({nm, " almost_full"}, 32'(almost_full_o[k]), 32'(fill >= AFL));
    checkOutput({nm, " almost_empty"}, 32'(almost_empty_o[k]), 32'(cnt <= AEL));
    checkOutput({nm, " pkt_dropped"}, 32'(pkt_dropped_o[k]), 32'(drop_pend[k]));
    if (cnt != 0) begin
      checkOutput({nm, " m_data"}, 32'(m_data_o[k]), 32'(cq[k][0][15:0]));
      checkOutput({nm, " m_last"}, 32'(m_last_o[k]), 32'(cq[k][0][16]));
    end
  endtask

  // Advance the model by one clock edge using the inputs that were presented.
  task automatic updateModel(input int k);
    int          fill;
    int          cnt;
    bit          isfull;
    bit          drop;
    logic [16:0] beat;
    fill   = cq[k].size() + sq[k].size();
    cnt    = cq[k].size();
    isfull = (fill == D);
    drop   = 1'b0;
    beat   = {s_last, s_data};
    if (m_ready && cnt != 0) void'(cq[k].pop_front());
    if (k == 0) begin
      if (s_valid && !isfull) cq[k].push_back(beat);
    end else if (disc[k]) begin
      if (s_valid && s_last) disc[k] = 1'b0;
    end else if (isfull && cnt == 0 && s_valid) begin
      sq[k].delete();
      drop    = 1'b1;
      disc[k] = 1'b1;
    end else if (s_valid && !isfull) begin
      if (s_last && s_drop) begin
        sq[k].delete();
        drop = 1'b1;
      end else begin
        sq[k].push_back(beat);
        if (s_last) begin
          while (sq[k].size() > 0) cq[k].push_back(sq[k].pop_front());
        end
      end
    end
    drop_pend[k] = drop;
  endtask

  // One cycle: drive inputs, check both instances, clock, advance the models.
  task automatic applyStimulus(input logic sv, input logic [15:0] sd, input logic sl,
                               input logic sdr, input logic mr);
    s_valid = sv;
    s_data  = sd;
    s_last  = sl;
    s_drop  = sdr;
    m_ready = mr;
    #1;
    compareDut(0);
    compareDut(1);
    @(posedge clk);
    updateModel(0);
    updateModel(1);
    @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    resetModel();
    for (int k = 0; k < 2; k++) begin
      compareDut(k);
      checkOutput({tag, " m_data"}, 32'(m_data_o[k]), 32'h0);
      checkOutput({tag, " m_last"}, 32'(m_last_o[k]), 32'h0);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_drop  = 1'b0;
    m_ready = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    // T1: fill to full one-beat packets, then drain in order.
    for (int i = 0; i < D; i++) applyStimulus(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd32, 1'b1, 1'b0, 1'b0);
    checkOutput("T1 full np", 32'(full_o[0]), 32'h1);
    for (int i = 0; i < D; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("T1 count np", 32'(count_o[0]), 32'h0);

    // T2: four-beat packet becomes visible only after its last beat.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h2000 + 16'(i), i == 3, 1'b0, 1'b0);
    checkOutput("T2 count pk", 32'(count_o[1]), 32'h4);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // T3: dropped packet followed by a good two-beat packet.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h3000 + 16'(i), i == 2, i == 2, 1'b0);
    checkOutput("T3 drop pk", 32'(pkt_dropped_o[1]), 32'h1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 16'h3100 + 16'(i), i == 1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // T4: oversize packet is discarded, the next one passes intact.
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 16'h4000 + 16'(i), i == 39, 1'b0, 1'b0);
    checkOutput("T4 count pk", 32'(count_o[1]), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h4100 + 16'(i), i == 2, 1'b0, 1'b0);
    for (int i = 0; i < 36; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // T5: random concurrent traffic near full, then near empty.
    for (int i = 0; i < 500; i++)
      applyStimulus(1'b1, 16'($urandom), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    for (int i = 0; i < 500; i++)
      applyStimulus($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 2) == 0,
                    $urandom_range(0, 15) == 0, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // T6: asynchronous reset mid-packet with five committed beats.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h6000 + 16'(i), i == 4, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 16'h6100 + 16'(i), 1'b0, 1'b0, 1'b0);
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkResetState("T6 reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 16'hA000 + 16'(i), i == 1, 1'b0, 1'b0);
    checkOutput("T6 first pk", 32'(m_data_o[1]), 32'hA000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
